// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: host-port and RAM-port signal bundle for ram_arbiter.
interface ram_arbiter_if #(parameter int MEM_SIZE = 65536);
   localparam int AW = $clog2(MEM_SIZE) - 2;
   logic          instr_req_i;
   logic          data_req_i;
   logic [31:0]   instr_addr_i;
   logic [31:0]   data_addr_i;
   logic          data_we_i;
   logic [3:0]    data_be_i;
   logic [31:0]   data_wdata_i;
   logic          instr_gnt_o;
   logic          data_gnt_o;
   logic          instr_rvalid_o;
   logic          data_rvalid_o;
   logic [31:0]   instr_rdata_o;
   logic [31:0]   data_rdata_o;
   logic          instr_err_o;
   logic          data_err_o;
   logic          ram_req_o;
   logic          ram_we_o;
   logic [3:0]    ram_be_o;
   logic [AW-1:0] ram_addr_o;
   logic [31:0]   ram_wdata_o;
   logic [31:0]   ram_rdata_i;
   modport slave (
      input  instr_req_i, data_req_i, instr_addr_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, ram_rdata_i,
      output instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o,
             instr_err_o, data_err_o, ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
   );
   modport master (
      output instr_req_i, data_req_i, instr_addr_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, ram_rdata_i,
      input  instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o,
             instr_err_o, data_err_o, ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the Ibex instr and data ports.
// Define RAM_ARB_RR_EN for round-robin; otherwise data-first with a MAX_BURST starvation guard.
module ram_arbiter #(
   parameter int          MEM_SIZE  = 65536,
   parameter logic [31:0] MEM_START = 32'h0000_0000,
   parameter int          MAX_BURST = 4
) (
   input logic          clk_i,
   input logic          rst_i,
   ram_arbiter_if.slave bus
);
   localparam int          AW   = $clog2(MEM_SIZE) - 2;
   localparam logic [31:0] MASK = ~(32'(MEM_SIZE) - 32'd1);
   logic          w_gnt_i, w_gnt_d, w_gnt, w_in_i, w_in_d, w_in;
   logic [AW-1:0] w_word;
   logic [31:0]   w_rdata;
   logic          r_valid, r_owner, r_err, r_we;
   assign w_in_i = (bus.instr_addr_i & MASK) == MEM_START;
   assign w_in_d = (bus.data_addr_i & MASK) == MEM_START;
`ifdef RAM_ARB_RR_EN
   logic r_last;
   // r_last=1 means instr was granted last, so data wins the next contention
   assign w_gnt_d = !rst_i && bus.data_req_i && (!bus.instr_req_i || r_last);
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) r_last <= 1'b0;
      else if (w_gnt) r_last <= w_gnt_i;
`else
   logic [3:0] r_burst;
   assign w_gnt_d = !rst_i && bus.data_req_i && !(bus.instr_req_i && r_burst == 4'(MAX_BURST));
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) r_burst <= '0;
      else if (w_gnt_i || !bus.instr_req_i) r_burst <= '0;
      else if (w_gnt_d && r_burst != 4'(MAX_BURST)) r_burst <= r_burst + 4'd1;
`endif
   assign w_gnt_i = !rst_i && bus.instr_req_i && !w_gnt_d;
   assign w_gnt   = w_gnt_i || w_gnt_d;
   assign w_in    = w_gnt_d ? w_in_d : w_in_i;
   assign w_word  = w_gnt_d ? bus.data_addr_i[AW+1:2] : bus.instr_addr_i[AW+1:2];
   assign bus.instr_gnt_o = w_gnt_i;
   assign bus.data_gnt_o  = w_gnt_d;
   assign bus.ram_req_o   = w_gnt && w_in;
   assign bus.ram_we_o    = w_gnt_d && bus.data_we_i;
   assign bus.ram_be_o    = w_gnt_d ? bus.data_be_i : {4{w_gnt_i}};
   assign bus.ram_addr_o  = w_gnt ? w_word : '0;
   assign bus.ram_wdata_o = w_gnt_d ? bus.data_wdata_i : '0;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_valid <= 1'b0;
         r_owner <= 1'b0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
      end else begin
         r_valid <= w_gnt;
         r_owner <= w_gnt_d;
         r_err   <= w_gnt && !w_in;
         r_we    <= w_gnt_d && bus.data_we_i;
      end
   // write acks and error responses return zero data
   assign w_rdata            = (r_valid && !r_err && !r_we) ? bus.ram_rdata_i : '0;
   assign bus.instr_rvalid_o = r_valid && !r_owner;
   assign bus.instr_rdata_o  = r_owner ? '0 : w_rdata;
   assign bus.instr_err_o    = r_err && !r_owner;
   assign bus.data_rvalid_o  = r_valid && r_owner;
   assign bus.data_rdata_o   = r_owner ? w_rdata : '0;
   assign bus.data_err_o     = r_err && r_owner;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors against a cycle-level arbitration/response model plus RAM macro.
module tb_ram_arbiter;
   localparam int MAX_BURST = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   ram_arbiter_if #(.MEM_SIZE(65536)) bus ();
   ram_arbiter #(.MEM_SIZE(65536), .MEM_START(32'h0), .MAX_BURST(MAX_BURST)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus)
   );
   logic [31:0] ram    [16384];
   logic [31:0] shadow [16384];
   int n_pass = 0;
   int n_total = 0;
   // RAM macro: synchronous, byte-enabled, read data one cycle after the strobe
   always @(posedge clk)
      if (bus.ram_req_o) begin
         for (int b = 0; b < 4; b++)
            if (bus.ram_we_o && bus.ram_be_o[b]) ram[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
         bus.ram_rdata_i <= ram[bus.ram_addr_o];
      end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask
   // Model: instr may wait at most MAX_BURST cycles; responses follow grants by one cycle
   int          m_wait;
   bit          m_last_i, p_valid, p_data, p_err;
   logic [31:0] p_rdata, m_a;
   bit          m_ri, m_rd, m_gi, m_gd, m_in, m_wr;
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_gnt_req", {29'd0, bus.instr_gnt_o, bus.data_gnt_o, bus.ram_req_o}, 32'd0);
         chk("rst_rvalid", {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'd0);
         m_wait = 0;
         m_last_i = 1'b0;
         p_valid = 1'b0;
      end else begin
         m_ri = bus.instr_req_i;
         m_rd = bus.data_req_i;
`ifdef RAM_ARB_RR_EN
         m_gd = m_rd && (!m_ri || m_last_i);
`else
         m_gd = m_rd && !(m_ri && m_wait >= MAX_BURST);
`endif
         m_gi = m_ri && !m_gd;
         m_a  = m_gd ? bus.data_addr_i : bus.instr_addr_i;
         m_in = (m_gi || m_gd) && m_a < 32'h0001_0000;
         m_wr = m_gd && bus.data_we_i;
         chk("gnt_i", 32'(bus.instr_gnt_o), 32'(m_gi));
         chk("gnt_d", 32'(bus.data_gnt_o), 32'(m_gd));
         chk("ram_req", 32'(bus.ram_req_o), 32'(m_in));
         if (m_in) begin
            chk("ram_addr", 32'(bus.ram_addr_o), 32'(m_a[15:2]));
            chk("ram_we", 32'(bus.ram_we_o), 32'(m_wr));
            chk("ram_be", 32'(bus.ram_be_o), m_gd ? 32'(bus.data_be_i) : 32'hF);
            if (m_wr) chk("ram_wdata", bus.ram_wdata_o, bus.data_wdata_i);
         end
         chk("rvalid_i", 32'(bus.instr_rvalid_o), 32'(p_valid && !p_data));
         chk("rdata_i", bus.instr_rdata_o, (p_valid && !p_data) ? p_rdata : 32'd0);
         chk("err_i", 32'(bus.instr_err_o), 32'(p_valid && !p_data && p_err));
         chk("rvalid_d", 32'(bus.data_rvalid_o), 32'(p_valid && p_data));
         chk("rdata_d", bus.data_rdata_o, (p_valid && p_data) ? p_rdata : 32'd0);
         chk("err_d", 32'(bus.data_err_o), 32'(p_valid && p_data && p_err));
         p_valid = m_gi || m_gd;
         p_data  = m_gd;
         p_err   = p_valid && !m_in;
         p_rdata = (m_in && !m_wr) ? shadow[m_a[15:2]] : 32'd0;
         if (m_in && m_wr)
            for (int b = 0; b < 4; b++)
               if (bus.data_be_i[b]) shadow[m_a[15:2]][8*b +: 8] = bus.data_wdata_i[8*b +: 8];
         m_wait = (m_ri && !m_gi) ? m_wait + 1 : 0;
         if (m_gi || m_gd) m_last_i = m_gi;
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_i(input bit r, input logic [31:0] a);
      bus.instr_req_i = r;
      bus.instr_addr_i = a;
   endtask
   task automatic set_d(input bit r, input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
      bus.data_req_i = r;
      bus.data_we_i = we;
      bus.data_be_i = be;
      bus.data_addr_i = a;
      bus.data_wdata_i = wd;
   endtask
   logic [11:0] pat;
   logic [31:0] addrs [6] = '{32'h10, 32'h20, 32'h22, 32'hFFFC, 32'h0001_0000, 32'h8000_0004};
   initial begin
      for (int i = 0; i < 16384; i++) begin
         ram[i] = 32'd0;
         shadow[i] = 32'd0;
      end
      ram[4] = 32'hDEADBEEF;
      shadow[4] = 32'hDEADBEEF;
      bus.ram_rdata_i = 32'd0;
      set_i(1'b1, 32'h10);
      set_d(1'b1, 1'b0, 4'hF, 32'h40, 32'd0);
      repeat (3) step();
      #2;
      chk("reset_hold_gnt", {30'd0, bus.instr_gnt_o, bus.data_gnt_o}, 32'd0);
      chk("reset_hold_ram_req", 32'(bus.ram_req_o), 32'd0);
      step();
      rst = 1'b0;
      pat = '0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) step();
         #2;
         pat = {pat[10:0], bus.data_gnt_o};
      end
`ifdef RAM_ARB_RR_EN
      chk("contention_pattern", 32'(pat), 32'(12'b0101_0101_0101));
`else
      chk("contention_pattern", 32'(pat), 32'(12'b1111_0111_1011));
`endif
      step();
      set_i(1'b0, 32'h0);
      set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) step();
      set_i(1'b1, 32'h10);
      #2;
      chk("read_gnt", 32'(bus.instr_gnt_o), 32'd1);
      chk("read_ram_addr", 32'(bus.ram_addr_o), 32'd4);
      step();
      set_i(1'b0, 32'h0);
      #2;
      chk("read_rvalid", 32'(bus.instr_rvalid_o), 32'd1);
      chk("read_rdata", bus.instr_rdata_o, 32'hDEADBEEF);
      chk("read_err", 32'(bus.instr_err_o), 32'd0);
      step();
      set_d(1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678);
      #2;
      chk("write_we", 32'(bus.ram_we_o), 32'd1);
      chk("write_be", 32'(bus.ram_be_o), 32'd3);
      step();
      set_d(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      #2;
      chk("write_ack_rvalid", 32'(bus.data_rvalid_o), 32'd1);
      chk("write_ack_rdata", bus.data_rdata_o, 32'd0);
      step();
      set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #2;
      chk("readback_rdata", bus.data_rdata_o, 32'h0000_5678);
      step();
      set_d(1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
      #2;
      chk("oor_gnt", 32'(bus.data_gnt_o), 32'd1);
      chk("oor_ram_req", 32'(bus.ram_req_o), 32'd0);
      step();
      set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #2;
      chk("oor_rvalid", 32'(bus.data_rvalid_o), 32'd1);
      chk("oor_err", 32'(bus.data_err_o), 32'd1);
      chk("oor_rdata", bus.data_rdata_o, 32'd0);
      step();
      set_i(1'b1, 32'h13);
      #2;
      chk("misaligned_addr", 32'(bus.ram_addr_o), 32'd4);
      step();
      set_i(1'b0, 32'h0);
      #2;
      chk("misaligned_rdata", bus.instr_rdata_o, 32'hDEADBEEF);
      chk("misaligned_err", 32'(bus.instr_err_o), 32'd0);
      step();
      set_i(1'b1, 32'h10);
      step();
      set_i(1'b0, 32'h0);
      rst = 1'b1;
      #2;
      chk("reset_drops_rvalid", 32'(bus.instr_rvalid_o), 32'd0);
      step();
      rst = 1'b0;
      repeat (40) begin
         step();
         set_i(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 5)]);
         set_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), addrs[$urandom_range(0, 5)], $urandom);
      end
      step();
      set_i(1'b0, 32'h0);
      set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
